// File: rtl/mul_hilo_if.sv
// EX-stage / multiplier-array bundle for the HI/LO multiply sequencer.
// master = EX stage plus multiplier array, slave = the sequencer.
interface mul_hilo_if;
    logic        req_valid;
    logic        req_sign;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hilo_wdata;
    logic        mul_sign;
    logic        mul_start_o;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic [63:0] mul_result;
    logic        stallreq;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req_valid, req_sign, req_op1, req_op2, flush,
        output hi_we, lo_we, hilo_wdata, mul_result,
        input  mul_sign, mul_start_o, mul_op1, mul_op2,
        input  stallreq, done, hi, lo
    );

    modport slave (
        input  req_valid, req_sign, req_op1, req_op2, flush,
        input  hi_we, lo_we, hilo_wdata, mul_result,
        output mul_sign, mul_start_o, mul_op1, mul_op2,
        output stallreq, done, hi, lo
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// Sequences a MULT/MULTU through a multicycle combinational multiplier,
// stalls EX while in flight and owns the HI/LO registers (incl. MTHI/MTLO).
module mul_hilo_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic      clk,
    input  logic      resetn,
    mul_hilo_if.slave bus
);
    localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      op1_q, op1_d, op2_q, op2_d;
    logic             sign_q, sign_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.hilo_wdata;
                if (bus.lo_we) lo_d = bus.hilo_wdata;
                if (bus.req_valid && !bus.flush) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    op1_d   = bus.req_op1;
                    op2_d   = bus.req_op2;
                    sign_d  = bus.req_sign;
                end
            end
            BUSY: begin
                // Flush wins over a capture landing in the same cycle.
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    hi_d    = bus.mul_result[63:32];
                    lo_d    = bus.mul_result[31:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // The stalled instruction retires here; req_valid must not re-trigger.
                if (bus.hi_we) hi_d = bus.hilo_wdata;
                if (bus.lo_we) lo_d = bus.hilo_wdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sign_q  <= sign_d;
        end
    end

    assign bus.mul_sign    = sign_q;
    assign bus.mul_op1     = op1_q;
    assign bus.mul_op2     = op2_q;
    assign bus.mul_start_o = (state_q == BUSY);
    assign bus.done        = (state_q == DONE);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.stallreq    = ((state_q == IDLE) && bus.req_valid && !bus.flush) ||
                             ((state_q == BUSY) && !bus.flush);
endmodule
